ar_access_sched: RTL and testbench
==================================

// Module: ar_access_sched
// PURPOSE
//  Sequencer/arbiter that owns the address register (AR) and the memory port.
//  Grants AR to one of two requesters: instruction fetch (sequential or jump) or data load/store.
//  Drives ARload/ARinc/AR input, strobes memory, waits for mem_rdy, then acks the winner.
//  Sits between the controller's fetch/execute logic and the AR + memory.
// PARAMETERS
//  AW         16  address width (AR / bus width)
//  STARVE_LIM 3   consecutive fetch losses before fetch is forced to win
//  MAX_WAIT   7   ACCESS cycles allowed before timeout (used only with AR_SCHED_TIMEOUT_EN)
// PORTS
//  clk         in   1   clock
//  rst         in   1   asynchronous, active-low reset
//  fetch_req   in   1   fetch request; held until fetch_ack
//  fetch_seq   in   1   1: next sequential address (AR+1); 0: jump to fetch_addr
//  fetch_addr  in   AW  jump target, stable while fetch_req
//  data_req    in   1   data access request; held until data_ack
//  data_we     in   1   1: write, 0: read
//  data_addr   in   AW  data address, stable while data_req
//  mem_rdy     in   1   memory completes the current access this cycle
//  ar_load     out  1   to AR ARload
//  ar_inc      out  1   to AR ARinc
//  ar_din      out  AW  to AR Din
//  mem_rd      out  1   memory read strobe
//  mem_wr      out  1   memory write strobe
//  fetch_ack   out  1   1-cycle pulse: fetch access complete
//  data_ack    out  1   1-cycle pulse: data access complete
//  busy        out  1   high in every state except IDLE
//  timeout_err out  1   sticky: an access timed out
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; ar_din=0; starve_cnt=0; ar_valid=0.
//  - FSM IDLE -> ADDR -> ACCESS -> DONE -> IDLE; outputs are a Moore decode of state plus registers.
//  - IDLE: sample the requests. Neither -> stay.
//    Only one -> grant it.
//    Both -> data wins, unless starve_cnt==STARVE_LIM, in which case fetch wins.
//    The granted address, type and we are latched on the grant.
//  - starve_cnt: +1 when fetch loses a contested grant; cleared when fetch is granted;
//    saturates at STARVE_LIM.
//  - ADDR (1 cycle):
//    - Data grant or fetch jump: ar_load=1, ar_din=latched address.
//    - Fetch with fetch_seq=1 and ar_valid=1: ar_inc=1, ar_load=0.
//    - fetch_seq=1 with ar_valid=0 (nothing loaded since reset): behaves as a jump to fetch_addr.
//    - ar_valid is set on any ar_load.
//    - Data access leaves AR at the data address. The fetch unit must issue a jump (fetch_seq=0)
//      after a data access; ar_access_sched does not restore AR.
//  - ACCESS: mem_rd=1 (fetch or data read) or mem_wr=1 (data write), held until mem_rdy=1.
//    mem_rdy is sampled every ACCESS cycle; go to DONE on the edge where mem_rdy=1.
//    mem_rdy outside ACCESS is ignored.
//  - DONE (1 cycle): pulse the granted ack; strobes low; -> IDLE.
//    A request still high in the IDLE cycle after DONE is treated as a new request.
//  - Latency: request high in IDLE cycle N -> ar_load/ar_inc in N+1 -> strobe from N+2
//    -> ack at N+3 when mem_rdy=1 in N+2.
//  - Requests dropped before ack: ignored; the access completes anyway, ack still pulses.
//  - Async reset mid-access: immediate return to IDLE, strobes drop, no ack, ar_valid=0.
// CONFIGURATION
//  AR_SCHED_TIMEOUT_EN
//    Defined: ACCESS cycle counter (starts at 1).
//      If MAX_WAIT cycles pass without mem_rdy: set timeout_err, go to DONE, ack the requester.
//      timeout_err clears only on reset.
//    Undefined: no counter; ACCESS waits indefinitely; timeout_err tied 0.
// TESTING
//  1. After reset, fetch_req=1, fetch_seq=1, fetch_addr=0x0040, mem_rdy=1
//     -> ar_load (not ar_inc) with ar_din=0x0040; mem_rd; fetch_ack at cycle N+3.
//  2. Then fetch_seq=1 again -> ar_inc=1, ar_load=0, AR=0x0041, fetch_ack.
//  3. fetch_req and data_req both held high, data_we=0, data_addr=0x1234
//     -> grant order D,D,D,F, then D, and the pattern repeats (STARVE_LIM=3).
//  4. data_req, data_we=1, data_addr=0xBEEF, mem_rdy delayed 3 cycles
//     -> mem_wr high for 4 cycles, mem_rd=0, single data_ack pulse.
//  5. Async rst low during ACCESS -> all outputs 0 immediately, no ack.
//     Next fetch_seq=1 is performed as a load.
//  6. With AR_SCHED_TIMEOUT_EN, mem_rdy held 0 -> ack after 7 ACCESS cycles, timeout_err=1 until reset.
//     Without the macro -> busy stays 1 and timeout_err stays 0.

Source files
------------

// File: rtl/ar_access_sched.sv
// ar_access_sched: arbitrates AR and the memory port between instruction fetch and data access.
// Define AR_SCHED_TIMEOUT_EN to bound ACCESS at MAX_WAIT cycles and flag sticky timeout_err.
module ar_access_sched #(
  parameter int AW = 16,
  parameter int STARVE_LIM = 3,
  parameter int MAX_WAIT = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic          fetch_seq,
  input  logic [AW-1:0] fetch_addr,
  input  logic          data_req,
  input  logic          data_we,
  input  logic [AW-1:0] data_addr,
  input  logic          mem_rdy,
  output logic          ar_load,
  output logic          ar_inc,
  output logic [AW-1:0] ar_din,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          fetch_ack,
  output logic          data_ack,
  output logic          busy,
  output logic          timeout_err
);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIM);
  typedef enum logic [1:0] {IDLE, ADDR, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic [AW-1:0] addr_q;
  logic is_data, we_q, inc_q, ar_valid, gnt_f, fin;
  logic [SW-1:0] starve_cnt;
  assign gnt_f = fetch_req && (!data_req || starve_cnt == SLIM);
`ifdef AR_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WLIM = CW'(MAX_WAIT);
  logic [CW-1:0] wait_cnt;
  logic tmo, terr_q;
  assign tmo = wait_cnt == WLIM && !mem_rdy;
  assign fin = mem_rdy || tmo;
  assign timeout_err = terr_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wait_cnt <= '0;
      terr_q <= 1'b0;
    end else begin
      wait_cnt <= state == ACCESS ? wait_cnt + 1'b1 : CW'(1);
      if (state == ACCESS && tmo) terr_q <= 1'b1;
    end
`else
  assign fin = mem_rdy;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      addr_q <= '0;
      is_data <= 1'b0;
      we_q <= 1'b0;
      inc_q <= 1'b0;
      ar_valid <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (fetch_req || data_req)) begin
        addr_q <= gnt_f ? fetch_addr : data_addr;
        is_data <= !gnt_f;
        we_q <= !gnt_f && data_we;
        inc_q <= gnt_f && fetch_seq && ar_valid;
        starve_cnt <= gnt_f ? '0 : (fetch_req && starve_cnt != SLIM) ? starve_cnt + 1'b1 : starve_cnt;
      end
      if (state == ADDR && !inc_q) ar_valid <= 1'b1;
    end
  always_comb begin
    state_nx = state == IDLE ? ((fetch_req || data_req) ? ADDR : IDLE) :
               state == ADDR ? ACCESS :
               state == ACCESS ? (fin ? DONE : ACCESS) : IDLE;
    ar_load = state == ADDR && !inc_q;
    ar_inc = state == ADDR && inc_q;
    ar_din = (state == ADDR && !inc_q) ? addr_q : '0;
    mem_rd = state == ACCESS && !we_q;
    mem_wr = state == ACCESS && we_q;
    fetch_ack = state == DONE && !is_data;
    data_ack = state == DONE && is_data;
    busy = state != IDLE;
  end
endmodule

// File: tb/tb_ar_access_sched.sv
// tb_ar_access_sched: directed scenarios plus random traffic against a per-transaction schedule model.
module tb_ar_access_sched;
  localparam int AW = 16, LIM = 3, MW = 7;
  typedef struct packed {
    logic ld, inc, rd, wr, fa, da, busy, terr, dchk, rset, rdy;
    logic [AW-1:0] din;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0;
  logic fetch_req = 1'b0, fetch_seq = 1'b0, data_req = 1'b0, data_we = 1'b0, mem_rdy = 1'b0;
  logic [AW-1:0] fetch_addr = '0, data_addr = '0;
  logic ar_load, ar_inc, mem_rd, mem_wr, fetch_ack, data_ack, busy, timeout_err;
  logic [AW-1:0] ar_din;
  ar_access_sched #(.AW(AW), .STARVE_LIM(LIM), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_seq(fetch_seq), .fetch_addr(fetch_addr),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .mem_rdy(mem_rdy),
    .ar_load(ar_load), .ar_inc(ar_inc), .ar_din(ar_din), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .fetch_ack(fetch_ack), .data_ack(data_ack), .busy(busy), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  // Expected outputs for each upcoming cycle; empty means the scheduler is idle and may grant.
  vec_t q[$];
  vec_t e;
  bit ack_log[$];
  int checks = 0, errors = 0, starve = 0, next_lat = -1;
  bit m_valid = 1'b0, m_terr = 1'b0;
  logic [AW-1:0] m_ar = '0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask
  function automatic vec_t idle_v();
    vec_t v = '0;
    v.terr = m_terr;
    return v;
  endfunction
  task automatic grant();
    bit gf, gd, inc, wr, to;
    logic [AW-1:0] a;
    int n;
    vec_t v;
    gf = fetch_req && (!data_req || starve == LIM);
    gd = data_req && !gf;
    if (!gf && !gd) return;
    starve = gf ? 0 : (fetch_req && starve < LIM) ? starve + 1 : starve;
    n = (next_lat >= 0 ? next_lat : int'($urandom_range(0, 3))) + 1;
    next_lat = -1;
    to = 1'b0;
`ifdef AR_SCHED_TIMEOUT_EN
    if (n > MW) begin
      n = MW;
      to = 1'b1;
    end
`endif
    inc = gf && fetch_seq && m_valid;
    a = gf ? fetch_addr : data_addr;
    wr = gd && data_we;
    m_ar = inc ? m_ar + 16'd1 : a;
    if (!inc) m_valid = 1'b1;
    v = idle_v(); v.busy = 1; v.ld = !inc; v.inc = inc; v.dchk = !inc; v.din = a;
    q.push_back(v);
    for (int i = 0; i < n; i++) begin
      v = idle_v(); v.busy = 1; v.rd = !wr; v.wr = wr; v.rset = 1; v.rdy = (i == n - 1) && !to;
      q.push_back(v);
    end
    m_terr = m_terr | to;
    v = idle_v(); v.busy = 1; v.fa = gf; v.da = gd;
    q.push_back(v);
    q.push_back(idle_v());
  endtask
  task automatic cyc();
    if (q.size() == 0 && rst) grant();
    @(posedge clk);
    #1;
    e = q.size() != 0 ? q.pop_front() : idle_v();
    chk("outputs", {ar_load, ar_inc, mem_rd, mem_wr, fetch_ack, data_ack, busy, timeout_err},
        {e.ld, e.inc, e.rd, e.wr, e.fa, e.da, e.busy, e.terr});
    if (e.dchk) chk("ar_din", ar_din, e.din);
    if (fetch_ack) ack_log.push_back(1'b1);
    if (data_ack) ack_log.push_back(1'b0);
    mem_rdy = e.rset ? e.rdy : 1'($urandom % 2);
  endtask
  task automatic async_reset();
    #1 rst = 1'b0;
    #1;
    chk("rst_outs", {ar_load, ar_inc, mem_rd, mem_wr, fetch_ack, data_ack, busy, timeout_err}, 0);
    chk("rst_din", ar_din, 0);
    q.delete();
    m_valid = 1'b0;
    starve = 0;
    m_terr = 1'b0;
    fetch_req = 1'b0;
    data_req = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
  endtask
  task automatic drain();
    while (q.size() != 0) begin
      cyc();
      if (fetch_ack) fetch_req = 1'b0;
      if (data_ack) data_req = 1'b0;
    end
  endtask
  initial begin
    int wr_n, rd_n, ack_n, guard;
    logic [8:0] pat;
    #3;
    chk("reset_outs", {ar_load, ar_inc, mem_rd, mem_wr, fetch_ack, data_ack, busy, timeout_err}, 0);
    chk("reset_din", ar_din, 0);
    repeat (2) cyc();
    rst = 1'b1;
    // first sequential fetch after reset must load, not increment
    fetch_req = 1; fetch_seq = 1; fetch_addr = 16'h0040; next_lat = 0;
    cyc();
    chk("t1_load", {ar_load, ar_inc}, 2'b10);
    chk("t1_din", ar_din, 16'h0040);
    cyc();
    chk("t1_rd", {mem_rd, mem_wr}, 2'b10);
    cyc();
    chk("t1_ack", fetch_ack, 1);
    next_lat = 0;
    cyc();
    cyc();
    chk("t2_inc", {ar_load, ar_inc}, 2'b01);
    chk("t2_ar_model", m_ar, 16'h0041);
    cyc();
    cyc();
    chk("t2_ack", fetch_ack, 1);
    // contested grants: data wins until fetch has lost LIM times in a row
    ack_log.delete();
    data_req = 1; data_we = 0; data_addr = 16'h1234;
    guard = 0;
    while (ack_log.size() < 9 && guard < 300) begin
      cyc();
      guard++;
    end
    chk("t3_count", ack_log.size(), 9);
    pat = 9'b010001000;
    for (int i = 0; i < 9 && i < ack_log.size(); i++) chk($sformatf("t3_order%0d", i), ack_log[i], pat[i]);
    fetch_req = 0; data_req = 0;
    drain();
    data_req = 1; data_we = 1; data_addr = 16'hBEEF; next_lat = 3;
    wr_n = 0; rd_n = 0; ack_n = 0;
    repeat (8) begin
      cyc();
      wr_n += int'(mem_wr); rd_n += int'(mem_rd); ack_n += int'(data_ack);
      if (data_ack) data_req = 0;
    end
    chk("t4_wr_cycles", wr_n, 4);
    chk("t4_rd_cycles", rd_n, 0);
    chk("t4_acks", ack_n, 1);
    fetch_req = 1; fetch_seq = 0; fetch_addr = 16'h2000; next_lat = 10;
    repeat (3) cyc();
    chk("t5_rd", mem_rd, 1);
    async_reset();
    fetch_req = 1; fetch_seq = 1; fetch_addr = 16'h0300; next_lat = 0;
    cyc();
    chk("t5_load", {ar_load, ar_inc}, 2'b10);
    chk("t5_din", ar_din, 16'h0300);
    drain();
    fetch_req = 1; fetch_seq = 0; fetch_addr = 16'h0500; next_lat = 20;
`ifdef AR_SCHED_TIMEOUT_EN
    rd_n = 0; guard = 0;
    while (!fetch_ack && guard < 40) begin
      cyc();
      rd_n += int'(mem_rd);
      guard++;
    end
    chk("t6_ack", fetch_ack, 1);
    chk("t6_access_cycles", rd_n, MW);
    chk("t6_terr", timeout_err, 1);
    fetch_req = 0;
    drain();
    repeat (3) cyc();
    chk("t6_terr_sticky", timeout_err, 1);
    async_reset();
    chk("t6_terr_clear", timeout_err, 0);
`else
    repeat (20) cyc();
    chk("t6_busy", busy, 1);
    chk("t6_terr", timeout_err, 0);
    drain();
`endif
    repeat (3000) begin
      cyc();
      if (fetch_ack || !fetch_req) begin
        fetch_req = ($urandom % 3) == 0;
        fetch_seq = ($urandom % 4) != 0;
        fetch_addr = 16'($urandom);
      end else if ($urandom % 64 == 0) fetch_req = 0;
      if (data_ack || !data_req) begin
        data_req = ($urandom % 3) == 0;
        data_we = 1'($urandom % 2);
        data_addr = 16'($urandom);
      end else if ($urandom % 64 == 0) data_req = 0;
      if (q.size() == 0 && $urandom % 20 == 0) next_lat = int'($urandom_range(5, 9));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
